// File: rtl/mac4_array_pkg.sv
// Shared widths, state encoding and the multiply-accumulate helper for the
// four-lane dot-product engine and the write-back stage that consumes it.
package mac4_array_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int COEF_W      = 7;
    localparam int PROD_W      = SAMPLE_W + COEF_W;
    localparam int RESULT_W    = 18;
    localparam int LANES       = 4;
    localparam int MAX_DOT_LEN = 8;
    localparam int K_W         = 3;
    localparam int ROW_W       = 4;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [COEF_W-1:0]   coef_t;
    typedef logic [RESULT_W-1:0] result_t;

    typedef struct packed {
        logic [K_W-1:0] k;
        logic [1:0]     lane;
    } coef_addr_t;

    // A row of at most 8 products of 255*127 stays below 2^18, so no saturation.
    function automatic result_t mac_step(input result_t acc, input sample_t din, input coef_t coef);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(din) * PROD_W'(coef);
        return acc + RESULT_W'(prod);
    endfunction

endpackage

// File: rtl/mac4_array_if.sv
// Sample/coefficient input bus and result/strobe output bus of mac4_array.
// The master side drives samples and coefficients; the slave side is the engine.
interface mac4_array_if;
    import mac4_array_pkg::*;

    logic       start;
    logic       coef_we;
    logic [4:0] coef_waddr;
    coef_t      coef_wdata;
    sample_t    din;
    logic       din_valid;
    logic       ready;
    logic       web;
    result_t    MU1;
    result_t    MU2;
    result_t    MU3;
    result_t    MU4;
    logic       done;

    modport master (
        output start, coef_we, coef_waddr, coef_wdata, din, din_valid,
        input  ready, web, MU1, MU2, MU3, MU4, done
    );

    modport slave (
        input  start, coef_we, coef_waddr, coef_wdata, din, din_valid,
        output ready, web, MU1, MU2, MU3, MU4, done
    );

endinterface

// File: rtl/mac4_array_mac_lane.sv
// One MAC lane: accumulates din*coef across a row and latches the completed
// dot product (including the final product) into a held result register.
module mac_lane
    import mac4_array_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear,
    input  logic    accept,
    input  logic    final_sample,
    input  sample_t din,
    input  coef_t   coef,
    output result_t result
);

    result_t acc_q;
    result_t acc_d;
    result_t result_q;
    result_t result_d;
    result_t sum;

    always_comb begin
        sum      = mac_step(acc_q, din, coef);
        acc_d    = acc_q;
        result_d = result_q;
        if (clear) begin
            acc_d = '0;
        end else if (accept) begin
            if (final_sample) begin
                acc_d    = '0;
                result_d = sum;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/mac4_array.sv
// Four-lane dot-product engine: coefficient register file, IDLE/RUN sequencer,
// sample and row counters, feeding registered results to the write-back stage.
module mac4_array
    import mac4_array_pkg::*;
#(
    parameter int DOT_LEN  = 4,
    parameter int NUM_ROWS = 16
) (
    input logic        clk,
    input logic        rst,
    mac4_array_if.slave bus
);

    localparam logic [K_W:0]     DOT_LEN_V = DOT_LEN[K_W:0];
    localparam logic [K_W-1:0]   LAST_K    = K_W'(DOT_LEN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [K_W-1:0]   k_q;
    logic [K_W-1:0]   k_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic             web_q;
    logic             web_d;
    logic             done_q;
    logic             done_d;
    coef_t            coef_q [MAX_DOT_LEN][LANES];
    coef_t            coef_d [MAX_DOT_LEN][LANES];

    coef_addr_t waddr;
    logic       clear_acc;
    logic       accept;
    logic       last_sample;
    result_t    lane_result [LANES];

    assign waddr = bus.coef_waddr;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        web_d       = 1'b0;
        done_d      = 1'b0;
        coef_d      = coef_q;
        clear_acc   = 1'b0;
        accept      = 1'b0;
        last_sample = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (bus.coef_we && ({1'b0, waddr.k} < DOT_LEN_V)) begin
                    coef_d[waddr.k][waddr.lane] = bus.coef_wdata;
                end
                if (bus.start) begin
                    state_d   = STATE_RUN;
                    k_d       = '0;
                    row_d     = '0;
                    clear_acc = 1'b1;
                end
            end
            STATE_RUN: begin
                if (bus.din_valid) begin
                    accept = 1'b1;
                    if (k_q == LAST_K) begin
                        // Row complete: lanes latch their results, strobe next cycle.
                        last_sample = 1'b1;
                        k_d         = '0;
                        web_d       = 1'b1;
                        if (row_q == LAST_ROW) begin
                            done_d  = 1'b1;
                            row_d   = '0;
                            state_d = STATE_IDLE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            web_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < MAX_DOT_LEN; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    coef_q[k][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            web_q   <= web_d;
            done_q  <= done_d;
            coef_q  <= coef_d;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        mac_lane u_lane (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear_acc),
            .accept       (accept),
            .final_sample (last_sample),
            .din          (bus.din),
            .coef         (coef_q[k_q][j]),
            .result       (lane_result[j])
        );
    end

    assign bus.ready = (state_q == STATE_RUN);
    assign bus.web   = web_q;
    assign bus.done  = done_q;
    assign bus.MU1   = lane_result[0];
    assign bus.MU2   = lane_result[1];
    assign bus.MU3   = lane_result[2];
    assign bus.MU4   = lane_result[3];

endmodule

// File: tb/tb_mac4_array.sv
// Directed bench for mac4_array: a single-row instance (dut_a) and a 16-row
// instance (dut_b) share one stimulus stream; expected values are hand-derived.
module tb_mac4_array;
    import mac4_array_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start;
    logic       coef_we;
    logic [4:0] coef_waddr;
    logic [6:0] coef_wdata;
    logic [7:0] din;
    logic       din_valid;

    int checks = 0;
    int errors = 0;

    int cycle     = 0;
    int web_cnt_b = 0;
    int done_cnt_b = 0;
    int last_web  = 0;
    int min_gap   = 1000;

    always #5 clk = ~clk;

    mac4_array_if bus_a ();
    mac4_array_if bus_b ();

    assign bus_a.start      = start;
    assign bus_a.coef_we    = coef_we;
    assign bus_a.coef_waddr = coef_waddr;
    assign bus_a.coef_wdata = coef_wdata;
    assign bus_a.din        = din;
    assign bus_a.din_valid  = din_valid;
    assign bus_b.start      = start;
    assign bus_b.coef_we    = coef_we;
    assign bus_b.coef_waddr = coef_waddr;
    assign bus_b.coef_wdata = coef_wdata;
    assign bus_b.din        = din;
    assign bus_b.din_valid  = din_valid;

    mac4_array #(.DOT_LEN(4), .NUM_ROWS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mac4_array #(.DOT_LEN(4), .NUM_ROWS(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Tracks web/done pulses of the 16-row instance and the tightest web spacing.
    always @(negedge clk) begin
        if (bus_b.web === 1'b1) begin
            if (web_cnt_b > 0 && (cycle - last_web) < min_gap) begin
                min_gap = cycle - last_web;
            end
            last_web  = cycle;
            web_cnt_b = web_cnt_b + 1;
        end
        if (bus_b.done === 1'b1) begin
            done_cnt_b = done_cnt_b + 1;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget exhausted, got %0d cycles, expected fewer", cycle);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic write_coef(input logic [2:0] k, input logic [1:0] j, input logic [6:0] val);
        coef_we    = 1'b1;
        coef_waddr = {k, j};
        coef_wdata = val;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic set_all_coef(input logic [6:0] val);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                write_coef(3'(k), 2'(j), val);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input int gap);
        din       = d;
        din_valid = 1'b0;
        repeat (gap) tick();
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic check_mu_a(input string tag, input int e0, input int e1, input int e2, input int e3);
        check_output({tag, "_a_mu1"}, 32'(bus_a.MU1), e0);
        check_output({tag, "_a_mu2"}, 32'(bus_a.MU2), e1);
        check_output({tag, "_a_mu3"}, 32'(bus_a.MU3), e2);
        check_output({tag, "_a_mu4"}, 32'(bus_a.MU4), e3);
    endtask

    task automatic check_mu_b(input string tag, input int e0, input int e1, input int e2, input int e3);
        check_output({tag, "_b_mu1"}, 32'(bus_b.MU1), e0);
        check_output({tag, "_b_mu2"}, 32'(bus_b.MU2), e1);
        check_output({tag, "_b_mu3"}, 32'(bus_b.MU3), e2);
        check_output({tag, "_b_mu4"}, 32'(bus_b.MU4), e3);
    endtask

    initial begin
        int cm [4][4];
        int expv [4];
        int base_web;
        int base_done;
        logic [7:0] d;

        start      = 1'b0;
        coef_we    = 1'b0;
        coef_waddr = '0;
        coef_wdata = '0;
        din        = '0;
        din_valid  = 1'b0;

        repeat (2) tick();
        check_output("rst_a_ready", 32'(bus_a.ready), 0);
        check_output("rst_a_web", 32'(bus_a.web), 0);
        check_output("rst_a_done", 32'(bus_a.done), 0);
        check_output("rst_b_ready", 32'(bus_b.ready), 0);
        check_mu_b("rst", 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // All coefficients 1, samples 1..4: every lane sums to 10.
        set_all_coef(7'd1);
        pulse_start();
        check_output("t1_a_ready", 32'(bus_a.ready), 1);
        check_output("t1_b_ready", 32'(bus_b.ready), 1);
        apply_stimulus(8'd1, 0);
        apply_stimulus(8'd2, 0);
        apply_stimulus(8'd3, 0);
        check_output("t1_web_early", 32'(bus_b.web), 0);
        apply_stimulus(8'd4, 0);
        check_output("t1_a_web", 32'(bus_a.web), 1);
        check_output("t1_a_done", 32'(bus_a.done), 1);
        check_output("t1_a_ready_fall", 32'(bus_a.ready), 0);
        check_output("t1_b_web", 32'(bus_b.web), 1);
        check_output("t1_b_done", 32'(bus_b.done), 0);
        check_mu_a("t1", 10, 10, 10, 10);
        tick();
        check_output("t1_a_web_single", 32'(bus_a.web), 0);
        check_output("t1_a_done_single", 32'(bus_a.done), 0);
        check_output("t1_a_ready_after", 32'(bus_a.ready), 0);
        check_output("t1_b_ready_after", 32'(bus_b.ready), 1);

        // C[k][j] = j+1, din = 2: lane j gives 8*(j+1).
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                write_coef(3'(k), 2'(j), 7'(j + 1));
            end
        end
        pulse_start();
        repeat (4) apply_stimulus(8'd2, 0);
        check_mu_a("t2", 8, 16, 24, 32);
        check_mu_b("t2", 8, 16, 24, 32);
        apply_stimulus(8'd9, 1);
        apply_stimulus(8'd9, 0);
        check_output("t2_b_no_web", 32'(bus_b.web), 0);
        check_mu_b("t2_hold", 8, 16, 24, 32);
        check_mu_a("t2_hold", 8, 16, 24, 32);

        // Full-scale operands: 4*255*127 = 129540 with no wrap.
        do_reset();
        set_all_coef(7'd127);
        pulse_start();
        repeat (4) apply_stimulus(8'd255, 0);
        check_mu_b("t3", 129540, 129540, 129540, 129540);
        check_output("t3_bit16", 32'(bus_b.MU4[16]), 1);

        // Sixteen rows with random gaps, a stray start and a stray coefficient write.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                cm[k][j] = 4 * k + j + 1;
                write_coef(3'(k), 2'(j), 7'(cm[k][j]));
            end
        end
        pulse_start();
        base_web  = web_cnt_b;
        base_done = done_cnt_b;
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 4; j++) expv[j] = 0;
            for (int k = 0; k < 4; k++) begin
                if (r == 5 && k == 2) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                if (r == 7 && k == 1) begin
                    write_coef(3'd0, 2'd0, 7'd99);
                end
                d = 8'(r * 3 + k + 1);
                for (int j = 0; j < 4; j++) expv[j] += int'(d) * cm[k][j];
                apply_stimulus(d, int'($urandom_range(0, 3)));
            end
            check_mu_b($sformatf("t4_r%0d", r), expv[0], expv[1], expv[2], expv[3]);
            check_output($sformatf("t4_r%0d_web", r), 32'(bus_b.web), 1);
            check_output($sformatf("t4_r%0d_done", r), 32'(bus_b.done), (r == 15) ? 1 : 0);
        end
        tick();
        check_output("t4_ready_end", 32'(bus_b.ready), 0);
        check_output("t4_web_count", 32'(web_cnt_b - base_web), 16);
        check_output("t4_done_count", 32'(done_cnt_b - base_done), 1);
        check_output("t4_min_gap_ok", 32'(min_gap >= 4), 1);

        // Reset two samples into row 3, then a fresh run must start clean.
        do_reset();
        set_all_coef(7'd1);
        pulse_start();
        repeat (3) begin
            repeat (4) apply_stimulus(8'd50, 0);
        end
        apply_stimulus(8'd50, 0);
        apply_stimulus(8'd50, 0);
        rst = 1'b0;
        tick();
        check_output("t5_rst_ready", 32'(bus_b.ready), 0);
        check_output("t5_rst_web", 32'(bus_b.web), 0);
        check_mu_b("t5_rst", 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        base_web = web_cnt_b;
        apply_stimulus(8'd50, 0);
        apply_stimulus(8'd50, 0);
        repeat (5) tick();
        check_output("t5_idle_no_web", 32'(web_cnt_b - base_web), 0);
        set_all_coef(7'd1);
        base_web  = web_cnt_b;
        base_done = done_cnt_b;
        pulse_start();
        repeat (4) apply_stimulus(8'd1, 0);
        check_mu_b("t5_row0", 4, 4, 4, 4);
        check_output("t5_row0_done", 32'(bus_b.done), 0);
        for (int r = 1; r < 16; r++) begin
            repeat (4) apply_stimulus(8'd1, 0);
            if (r == 14) check_output("t5_row14_done", 32'(bus_b.done), 0);
        end
        check_output("t5_row15_done", 32'(bus_b.done), 1);
        tick();
        check_output("t5_web_count", 32'(web_cnt_b - base_web), 16);
        check_output("t5_done_count", 32'(done_cnt_b - base_done), 1);

        // Writes to k >= DOT_LEN must not disturb the live coefficients.
        do_reset();
        set_all_coef(7'd1);
        write_coef(3'd5, 2'd0, 7'd100);
        write_coef(3'd4, 2'd3, 7'd100);
        pulse_start();
        apply_stimulus(8'd1, 0);
        apply_stimulus(8'd2, 0);
        apply_stimulus(8'd3, 0);
        apply_stimulus(8'd4, 0);
        check_mu_b("t6", 10, 10, 10, 10);
        check_mu_a("t6", 10, 10, 10, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac4_array.md
Name: mac4_array

Overview:
- Compute stage directly upstream of the RAM write-back stage.
- Holds a DOT_LEN×4 coefficient matrix and streams input rows of DOT_LEN unsigned 8-bit samples.
- For each row, four parallel MAC lanes produce four 18-bit dot products. These are presented on MU1..MU4 with a one-cycle web strobe, in the exact format the write-back stage consumes.
- One run processes NUM_ROWS rows, giving NUM_ROWS×4 results (64 at defaults, matching the 6-bit write-back address space).

Parameters:
- DOT_LEN, 4, samples per row / MAC depth; legal range 4..8. The minimum of 4 guarantees at least 4 cycles between web pulses, as the write-back stage requires.
- NUM_ROWS, 16, rows per run; legal range 1..16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when in IDLE
- coef_we  in  1  coefficient write strobe
- coef_waddr  in  5  coefficient index: [4:2] = k (sample index), [1:0] = j (lane)
- coef_wdata  in  7  unsigned coefficient C[k][j]
- din  in  8  unsigned input sample
- din_valid  in  1  din qualifier
- ready  out  1  high when a sample can be accepted (state RUN)
- web  out  1  one-cycle strobe: MU1..MU4 hold a new result set
- MU1  out  18  lane 0 result (written first by write-back)
- MU2  out  18  lane 1 result
- MU3  out  18  lane 2 result
- MU4  out  18  lane 3 result
- done  out  1  one-cycle pulse coincident with the final web of a run

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - state to IDLE; ready=0, web=0, done=0
  - MU1..MU4 to 0
  - all accumulators, the sample counter k and the row counter to 0
  - all coefficient registers to 0
- Reset mid-run aborts the run; no further web until a new start.
- FSM IDLE:
  - coef_we=1 writes coef_wdata into C[k][j] at the clock edge.
  - Writes with k ≥ DOT_LEN are ignored.
  - start=1 moves to RUN and clears k, row and accumulators. If start and coef_we are both high, the write is performed and the run starts.
- FSM RUN:
  - ready=1. A sample is accepted on a clock edge with din_valid=1.
  - Each accepted sample updates every lane: acc_j += din × C[k][j]. Product is 15 bits; accumulator is 18 bits unsigned. The DOT_LEN ≤ 8 bound means no overflow (max 259080). No saturation logic.
  - k increments per accepted sample.
  - On acceptance of sample k=DOT_LEN-1:
    - MUj+1 <= acc_j + din × C[k][j], so the final product is included.
    - Accumulators and k clear.
    - web <= 1 for exactly the next cycle.
    - Row increments.
  - MU1..MU4 stay stable until the next row completes, at least 4 cycles after web. The write-back stage samples MU2..MU4 on the web cycle.
  - din_valid=0 cycles stall with no state change. Gaps between samples are legal at any k.
  - start and coef_we are ignored in RUN.
  - When the completed row is row NUM_ROWS-1:
    - done <= 1, in the same cycle as that final web.
    - State returns to IDLE at the accepting edge, so ready falls there.
- Latency: web is high in the cycle after the edge accepting the last sample of a row.
- Outputs web, done, MU1..MU4 and ready are all registered or decoded from registered state; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds: sample width 8, coefficient width 7, result width 18, lane count 4, state encoding IDLE/RUN. The write-back stage uses the same result-width constant.
- Natural sub-module: mac_lane. It holds one accumulator and computes acc + din×coef, with a clear input and a "final" input. It is instantiated 4 times.
- The top level owns the FSM, the counters and the coefficient register file.

Test Plan:
- All C=1, DOT_LEN=4, NUM_ROWS=1, start, din=1,2,3,4 back-to-back -> web single pulse 1 cycle after 4th accept; MU1..MU4=10; done with web; ready=0 afterwards.
- C[k][j]=j+1, din=2 ×4 -> MU1=8, MU2=16, MU3=24, MU4=32; values held until the next row.
- All C=127, din=255 ×4 -> every MU=129540; bits [17] and up correct with no wrap.
- NUM_ROWS=16, din_valid with random gaps -> exactly 16 web pulses, each ≥4 cycles apart; done only on the 16th; start asserted mid-run is ignored; coef_we in RUN leaves C unchanged.
- rst low after 2 samples of row 3, then a new start with din=1 ×4 and C=1 -> no stale contribution; MU=4; row numbering restarts (16 further webs).
- coef_we with coef_waddr k=5 while DOT_LEN=4 -> ignored; a subsequent run gives results matching the unchanged C.
